// File: rtl/tc_pipe_pkg.sv
// Shared definitions for the pipelined true/complement unit: mode encodings
// and width-dependent extreme values of a two's-complement sample.
package tc_pipe_pkg;

  typedef enum logic [1:0] {
    TC_PASS = 2'd0,
    TC_NEG  = 2'd1,
    TC_CMP  = 2'd2,
    TC_ABS  = 2'd3
  } tc_mode_e;

  // Callers narrow the 64-bit result to their own width W (4..64).
  function automatic logic [63:0] tc_most_neg(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

  function automatic logic [63:0] tc_most_pos(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/tc_pipe_if.sv
// Streaming bus of tc_pipe: sample/tag/mode input side, result output side,
// overflow reporting and sticky clear.
interface tc_pipe_if
  import tc_pipe_pkg::*;
#(
  parameter int W    = 18,
  parameter int TAGW = 2
);
  logic [W-1:0]    D;
  logic [TAGW-1:0] TI;
  tc_mode_e        MODE;
  logic            CMP;
  logic            VI;
  logic            RI;
  logic [W-1:0]    Y;
  logic [TAGW-1:0] TO;
  logic            VO;
  logic            RO;
  logic            OVF;
  logic            OVFS;
  logic            CLR;

  modport master (
    output D, TI, MODE, CMP, VI, RO, CLR,
    input  RI, Y, TO, VO, OVF, OVFS
  );

  modport slave (
    input  D, TI, MODE, CMP, VI, RO, CLR,
    output RI, Y, TO, VO, OVF, OVFS
  );
endinterface

// File: rtl/tc_pipe_stage.sv
// Generic valid/ready register slice: captures payload and valid whenever
// it is empty or downstream is taking the current contents.
module tc_pipe_stage #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vin,
  input  logic [PW-1:0] din,
  input  logic          rdy,
  output logic          load,
  output logic          vout,
  output logic [PW-1:0] dout
);

  assign load = !vout || rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vout <= 1'b0;
      dout <= '0;
    end else if (load) begin
      vout <= vin;
      dout <= din;
    end
  end

endmodule

// File: rtl/tc_pipe.sv
// Two-stage pipelined true/complement unit: pass, negate, CMP-controlled
// complement or absolute value, with optional saturation and sticky overflow.
module tc_pipe
  import tc_pipe_pkg::*;
#(
  parameter int W    = 18,
  parameter int SAT  = 1,
  parameter int TAGW = 2
) (
  input logic     CLK,
  input logic     RSTN,
  tc_pipe_if.slave bus
);

  localparam logic [W-1:0] MOST_NEG = W'(tc_most_neg(W));
  localparam logic [W-1:0] MOST_POS = W'(tc_most_pos(W));
  localparam int P1W = TAGW + 2 + W;
  localparam int P2W = TAGW + 1 + W;

  logic           neg;
  logic [P1W-1:0] p1_d, p1_q;
  logic [P2W-1:0] p2_d, p2_q;
  logic           v1, load1, load2;
  logic [W-1:0]   x1, y2;
  logic           c1, mn1;
  logic [TAGW-1:0] t1;
  logic           ovfs;

  always_comb begin
    neg = 1'b0;
    case (bus.MODE)
      TC_PASS: neg = 1'b0;
      TC_NEG:  neg = 1'b1;
      TC_CMP:  neg = bus.CMP;
      TC_ABS:  neg = bus.D[W-1];
      default: neg = 1'b0;
    endcase
  end

  // Stage 1 carries the one's complement plus the pending +1, so the adder
  // sits entirely in stage 2.
  assign p1_d = {bus.TI, neg & (bus.D == MOST_NEG), neg, neg ? ~bus.D : bus.D};

  assign x1  = p1_q[W-1:0];
  assign c1  = p1_q[W];
  assign mn1 = p1_q[W+1];
  assign t1  = p1_q[P1W-1 -: TAGW];

  always_comb begin
    y2 = x1 + {{(W-1){1'b0}}, c1};
    if (SAT != 0 && mn1) y2 = MOST_POS;
  end

  assign p2_d = {t1, mn1, y2};

  tc_pipe_stage #(.PW(P1W)) u_s1 (
    .clk   (CLK),
    .rst_n (RSTN),
    .vin   (bus.VI),
    .din   (p1_d),
    .rdy   (load2),
    .load  (load1),
    .vout  (v1),
    .dout  (p1_q)
  );

  tc_pipe_stage #(.PW(P2W)) u_s2 (
    .clk   (CLK),
    .rst_n (RSTN),
    .vin   (v1),
    .din   (p2_d),
    .rdy   (bus.RO),
    .load  (load2),
    .vout  (bus.VO),
    .dout  (p2_q)
  );

  assign bus.RI  = load1;
  assign bus.Y   = p2_q[W-1:0];
  assign bus.TO  = p2_q[P2W-1 -: TAGW];
  // Bubbles load stale stage-1 flags, so the flag is qualified by valid.
  assign bus.OVF = bus.VO & p2_q[W];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ovfs <= 1'b0;
    end else if (bus.VO && bus.RO && bus.OVF) begin
      ovfs <= 1'b1;
    end else if (bus.CLR) begin
      ovfs <= 1'b0;
    end
  end

  assign bus.OVFS = ovfs;

endmodule

// File: tb/tb_tc_pipe.sv
// Directed bench for tc_pipe: saturating (SAT=1) and wrapping (SAT=0)
// instances share one stimulus stream.
module tb_tc_pipe;
  import tc_pipe_pkg::*;

  localparam int W    = 18;
  localparam int TAGW = 2;

  logic CLK = 1'b0;
  logic RSTN;
  int   tests = 0;
  int   fails = 0;

  tc_pipe_if #(.W(W), .TAGW(TAGW)) a ();
  tc_pipe_if #(.W(W), .TAGW(TAGW)) b ();

  assign b.D    = a.D;
  assign b.TI   = a.TI;
  assign b.MODE = a.MODE;
  assign b.CMP  = a.CMP;
  assign b.VI   = a.VI;
  assign b.RO   = a.RO;
  assign b.CLR  = a.CLR;

  tc_pipe #(.W(W), .SAT(1), .TAGW(TAGW)) dut_sat (.CLK(CLK), .RSTN(RSTN), .bus(a));
  tc_pipe #(.W(W), .SAT(0), .TAGW(TAGW)) dut_wrap (.CLK(CLK), .RSTN(RSTN), .bus(b));

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Present one sample for one cycle; returns with its result on the output.
  task automatic send(input tc_mode_e m, input logic c, input logic [W-1:0] d,
                      input logic [TAGW-1:0] t);
    a.MODE = m; a.CMP = c; a.D = d; a.TI = t; a.VI = 1'b1;
    tick();
    a.VI = 1'b0;
    tick();
  endtask

  bit pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before $finish");
    $fatal(1);
  end

  initial begin
    int unsigned sent, got;
    logic hold;
    logic [W-1:0] hy, sv, ev;
    logic [TAGW-1:0] ht;
    logic acc, xfer;

    RSTN = 1'b0;
    a.D = '0; a.TI = '0; a.MODE = TC_PASS; a.CMP = 1'b0;
    a.VI = 1'b0; a.RO = 1'b1; a.CLR = 1'b0;
    tick(); tick();
    chkb("rst_vo",   a.VO,   1'b0);
    chk ("rst_y",    32'(a.Y),  32'h0);
    chk ("rst_to",   32'(a.TO), 32'h0);
    chkb("rst_ovf",  a.OVF,  1'b0);
    chkb("rst_ovfs", a.OVFS, 1'b0);
    chkb("rst_ri",   a.RI,   1'b1);
    RSTN = 1'b1;
    tick();

    // Negate stream, latency 2, throughput 1
    a.MODE = TC_NEG; a.VI = 1'b1; a.D = 18'h00005;
    tick();
    a.D = 18'h3FFFB;
    tick();
    chkb("neg_vo",   a.VO, 1'b1);
    chk ("neg_y0",   32'(a.Y), 32'h3FFFB);
    chkb("neg_ovf0", a.OVF, 1'b0);
    a.D = 18'h00000;
    tick();
    chk ("neg_y1",   32'(a.Y), 32'h00005);
    chkb("neg_ovf1", a.OVF, 1'b0);
    a.VI = 1'b0;
    tick();
    chk ("neg_y2",   32'(a.Y), 32'h00000);
    chkb("neg_vo2",  a.VO, 1'b1);
    chkb("neg_ovf2", a.OVF, 1'b0);
    tick();
    chkb("neg_drain", a.VO, 1'b0);

    // Absolute value of the most-negative sample
    send(TC_ABS, 1'b0, 18'h20000, 2'd2);
    chk ("abs_min_sat_y",   32'(a.Y), 32'h1FFFF);
    chkb("abs_min_sat_ovf", a.OVF, 1'b1);
    chk ("abs_min_sat_to",  32'(a.TO), 32'h2);
    chk ("abs_min_wrap_y",  32'(b.Y), 32'h20000);
    chkb("abs_min_wrap_ovf", b.OVF, 1'b1);
    chkb("ovfs_before_xfer", a.OVFS, 1'b0);
    tick();
    chkb("ovfs_set_sat",  a.OVFS, 1'b1);
    chkb("ovfs_set_wrap", b.OVFS, 1'b1);
    chkb("abs_min_drain", a.VO, 1'b0);
    a.CLR = 1'b1;
    tick();
    chkb("ovfs_clr", a.OVFS, 1'b0);
    a.CLR = 1'b0;

    send(TC_ABS, 1'b0, 18'h3FFF9, 2'd1);
    chk ("abs_neg_y",   32'(a.Y), 32'h7);
    chkb("abs_neg_ovf", a.OVF, 1'b0);
    tick();
    send(TC_ABS, 1'b0, 18'h00009, 2'd3);
    chk ("abs_pos_y",  32'(a.Y), 32'h9);
    chk ("abs_pos_to", 32'(a.TO), 32'h3);
    tick();

    // Set and clear of OVFS in the same cycle
    send(TC_NEG, 1'b0, 18'h20000, 2'd0);
    chkb("neg_min_ovf", a.OVF, 1'b1);
    chk ("neg_min_y",   32'(a.Y), 32'h1FFFF);
    a.CLR = 1'b1;
    tick();
    chkb("ovfs_set_wins", a.OVFS, 1'b1);
    tick();
    chkb("ovfs_clr_alone", a.OVFS, 1'b0);
    a.CLR = 1'b0;

    // CMP-controlled complement with alternating tag
    a.MODE = TC_CMP; a.VI = 1'b1; a.D = 18'd100; a.CMP = 1'b1; a.TI = 2'd0;
    tick();
    a.CMP = 1'b0; a.TI = 2'd1;
    tick();
    chk ("cmp1_y",  32'(a.Y), 32'h3FF9C);
    chk ("cmp1_to", 32'(a.TO), 32'h0);
    a.VI = 1'b0;
    tick();
    chk ("cmp0_y",  32'(a.Y), 32'd100);
    chk ("cmp0_to", 32'(a.TO), 32'h1);
    tick();

    // Backpressure stream of 8 negations
    a.MODE = TC_NEG;
    sent = 0; got = 0; hold = 1'b0; hy = '0; ht = '0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      a.RO = (c < 8) ? pat[c] : 1'b1;
      a.VI = (sent < 8);
      sv   = 18'(sent * 5 + 3);
      a.D  = sv;
      a.TI = 2'(sent);
      #1;
      if (hold) begin
        chkb("bp_hold_vo", a.VO, 1'b1);
        chk ("bp_hold_y",  32'(a.Y),  32'(hy));
        chk ("bp_hold_to", 32'(a.TO), 32'(ht));
      end
      chkb("bp_ri", a.RI, !((sent - got) == 2 && !a.RO));
      acc  = a.VI & a.RI;
      xfer = a.VO & a.RO;
      if (xfer) begin
        ev = 18'(18'd0 - 18'(got * 5 + 3));
        chk("bp_y",  32'(a.Y),  32'(ev));
        chk("bp_to", 32'(a.TO), 32'(2'(got)));
        got++;
      end
      hold = a.VO & !a.RO;
      hy = a.Y; ht = a.TO;
      if (acc) sent++;
      tick();
    end
    chk ("bp_count", got, 32'd8);
    a.VI = 1'b0; a.RO = 1'b1;
    tick();
    chkb("bp_empty", a.VO, 1'b0);

    // Asynchronous reset with two samples in flight
    a.MODE = TC_PASS; a.VI = 1'b1; a.D = 18'h00011; a.TI = 2'd1;
    tick();
    a.D = 18'h00022;
    tick();
    chk ("pass_y", 32'(a.Y), 32'h11);
    a.VI = 1'b0;
    RSTN = 1'b0;
    #1;
    chkb("arst_vo",   a.VO, 1'b0);
    chk ("arst_y",    32'(a.Y), 32'h0);
    chkb("arst_ovfs", a.OVFS, 1'b0);
    tick();
    RSTN = 1'b1;
    tick();
    chkb("arst_stale0", a.VO, 1'b0);
    tick();
    chkb("arst_stale1", a.VO, 1'b0);
    a.VI = 1'b1; a.D = 18'h00033; a.TI = 2'd3;
    tick();
    a.VI = 1'b0;
    chkb("arst_lat1", a.VO, 1'b0);
    tick();
    chkb("arst_lat2_vo", a.VO, 1'b1);
    chk ("arst_lat2_y",  32'(a.Y), 32'h33);
    tick();
    chkb("arst_done", a.VO, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
